extensor_pipe: RTL
==================

EXTENSOR_PIPE -- requirements
Module: extensor_pipe

Interface
REQ-001 SHALL have parameter LARGURA_ENTRADA, default 26, width of the immediate/target field.
REQ-002 SHALL have parameter LARGURA_SAIDA, default 32, width of the extended result and of pc.
REQ-003 SHALL have parameter DESLOCAMENTO, default 2, left-shift amount for modes 2 and 3.
REQ-004 SHALL be legal only with LARGURA_ENTRADA <= LARGURA_SAIDA and DESLOCAMENTO < LARGURA_SAIDA; elaboration SHALL fail otherwise.
REQ-005 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port entrada_valida, input, 1, the producer offers an item.
REQ-008 SHALL have port entrada_pronta, output, 1, the block can accept an item.
REQ-009 SHALL have port entrada, input, LARGURA_ENTRADA, the field to extend.
REQ-010 SHALL have port modo, input, 2, the operation, sampled together with entrada.
REQ-011 SHALL have port pc, input, LARGURA_SAIDA, the program counter, sampled together with entrada.
REQ-012 SHALL have port saida_valida, output, 1, saida holds a valid result.
REQ-013 SHALL have port saida_pronta, input, 1, the consumer accepts the result.
REQ-014 SHALL have port saida, output, LARGURA_SAIDA, the extended result.
REQ-015 SHALL have port estouro, output, 1, the overflow flag, qualified by saida_valida.
REQ-016 SHALL have port ocupacao, output, 2, the number of items held (0..2).

Function
REQ-017 SHALL accept an item on a rising edge where entrada_valida=1 and entrada_pronta=1.
REQ-018 SHALL complete an output on a rising edge where saida_valida=1 and saida_pronta=1.
REQ-019 SHALL compute the result from the sampled entrada, modo and pc, and SHALL register it with 1-cycle latency: saida_valida=1 in the cycle after acceptance if the output stage was empty.
REQ-020 SHALL, for modo=0, zero-extend: result = {zeros, entrada}, estouro=0.
REQ-021 SHALL, for modo=1, sign-extend by replicating entrada[LARGURA_ENTRADA-1], estouro=0.
REQ-022 SHALL, for modo=2, sign-extend, shift left by DESLOCAMENTO, and truncate to LARGURA_SAIDA; estouro=1 iff the discarded bits and the new result MSB are not all equal.
REQ-023 SHALL, for modo=3 (jump), compute result = (pc with bits below LARGURA_ENTRADA+DESLOCAMENTO cleared) OR (zero-extended entrada << DESLOCAMENTO), truncated to LARGURA_SAIDA, with estouro=0.
REQ-024 SHALL hold up to two items: one output register plus one skid register; ocupacao SHALL reflect the count after each edge.
REQ-025 SHALL drive entrada_pronta = (ocupacao < 2) AND NOT reset, with no combinational path from saida_pronta.
REQ-026 SHALL keep saida/estouro stable while saida_valida=1 and saida_pronta=0.
REQ-027 SHALL, on simultaneous accept and complete, keep ocupacao unchanged and preserve FIFO order; the skid item moves to the output register before the new item.
REQ-028 SHALL never reorder, drop or duplicate items.
REQ-029 SHALL treat a modo, entrada or pc change without an accept as having no effect.

Reset
REQ-030 SHALL, on a rising edge with reset=1, set saida_valida=0, saida=0, estouro=0 and ocupacao=0, and SHALL discard any buffered items, including mid-transfer items.
REQ-031 SHALL hold entrada_pronta=0 while reset=1, and SHALL set entrada_pronta=1 in the first cycle after reset is released.
REQ-032 SHALL give reset priority over simultaneous accept and complete events.

Verification
REQ-033 SHALL cover zero-extend at defaults: modo=0, entrada=26'h3FFFFFF -> next cycle saida_valida=1, saida=32'h03FFFFFF, estouro=0.
REQ-034 SHALL cover sign-extend at defaults: modo=1, entrada=26'h2000000 -> saida=32'hFE000000.
REQ-035 SHALL cover jump at defaults: modo=3, pc=32'hA0000000, entrada=26'h0000010 -> saida=32'hA0000040.
REQ-036 SHALL cover the overflow case with LARGURA_ENTRADA=16, LARGURA_SAIDA=16, DESLOCAMENTO=2: modo=2, entrada=16'h4001 -> saida=16'h0004, estouro=1; entrada=16'hFFFF -> saida=16'hFFFC, estouro=0.
REQ-037 SHALL cover backpressure: with saida_pronta=0, offer A,B,C on consecutive cycles -> A and B accepted, ocupacao=2, entrada_pronta=0, C held; then saida_pronta=1 -> A, B, C emerge in order with no gaps once flowing.
REQ-038 SHALL cover reset mid-operation: with ocupacao=2, assert reset for 1 cycle -> saida_valida=0, ocupacao=0, saida=0; the next accepted item appears alone one cycle later.

Source files
------------

// File: rtl/extensor_pipe.sv
// -----------------------------------------------------------------------------
// extensor_pipe
//   Immediate / jump-target extender with a valid/ready handshake on both sides.
//   Each accepted item (entrada, modo, pc) is turned into one result:
//     modo 0 : zero-extend entrada
//     modo 1 : sign-extend entrada
//     modo 2 : sign-extend, shift left by DESLOCAMENTO, flag signed overflow
//     modo 3 : jump target = upper pc bits | (entrada << DESLOCAMENTO)
//   Results leave through a two-entry buffer (output register + skid register),
//   so entrada_pronta never depends combinationally on saida_pronta.
//
// Ports
//   clock          : single clock, rising edge
//   reset          : synchronous, active-high; clears all buffered items
//   entrada_valida : producer offers an item
//   entrada_pronta : block can accept an item (low during reset)
//   entrada        : field to extend            [LARGURA_ENTRADA]
//   modo           : operation select           [2]
//   pc             : program counter            [LARGURA_SAIDA]
//   saida_valida   : saida/estouro hold a valid result
//   saida_pronta   : consumer takes the result
//   saida          : extended result            [LARGURA_SAIDA]
//   estouro        : overflow flag, qualified by saida_valida
//   ocupacao       : number of items held (0..2)
// -----------------------------------------------------------------------------
module extensor_pipe #(
  parameter int LARGURA_ENTRADA = 26,
  parameter int LARGURA_SAIDA   = 32,
  parameter int DESLOCAMENTO    = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       entrada_valida,
  output logic                       entrada_pronta,
  input  logic [LARGURA_ENTRADA-1:0] entrada,
  input  logic [1:0]                 modo,
  input  logic [LARGURA_SAIDA-1:0]   pc,
  output logic                       saida_valida,
  input  logic                       saida_pronta,
  output logic [LARGURA_SAIDA-1:0]   saida,
  output logic                       estouro,
  output logic [1:0]                 ocupacao
);

  localparam int LW    = LARGURA_SAIDA + DESLOCAMENTO;
  localparam int CORTE = LARGURA_ENTRADA + DESLOCAMENTO;

  // Keeps the pc bits at and above CORTE. When CORTE >= LARGURA_SAIDA the
  // shifted one falls off the top, the subtraction yields all ones and the
  // mask becomes zero, which is exactly "no pc bits survive".
  localparam logic [LARGURA_SAIDA-1:0] MASCARA_PC =
    ~((LARGURA_SAIDA'(1) << CORTE) - LARGURA_SAIDA'(1));

  if (LARGURA_ENTRADA > LARGURA_SAIDA || DESLOCAMENTO >= LARGURA_SAIDA ||
      DESLOCAMENTO < 0) begin : g_param_invalido
    $error("extensor_pipe: illegal parameter combination");
  end

  // ---------------------------------------------------------------------------
  // Datapath: result of the item currently offered on the input side
  // ---------------------------------------------------------------------------
  logic [LW-1:0]            w_sinal_desl;  // sign-extended then shifted, untruncated
  logic [LW-1:0]            w_zero_desl;   // zero-extended then shifted
  logic [DESLOCAMENTO:0]    w_bits_topo;   // discarded bits plus new MSB
  logic [LARGURA_SAIDA-1:0] w_resultado;
  logic                     w_estouro;

  assign w_sinal_desl = LW'($signed(entrada)) << DESLOCAMENTO;
  assign w_zero_desl  = LW'(entrada) << DESLOCAMENTO;
  assign w_bits_topo  = w_sinal_desl[LW-1:LARGURA_SAIDA-1];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a value unassigned and infer a latch.
  always_comb begin
    w_resultado = '0;
    w_estouro   = 1'b0;
    case (modo)
      2'd0: w_resultado = LARGURA_SAIDA'(entrada);
      2'd1: w_resultado = LARGURA_SAIDA'($signed(entrada));
      2'd2: begin
        w_resultado = w_sinal_desl[LARGURA_SAIDA-1:0];
        // Signed overflow: the bits shifted out and the new sign bit disagree.
        w_estouro   = ~((&w_bits_topo) | (~|w_bits_topo));
      end
      2'd3: w_resultado = (pc & MASCARA_PC) | w_zero_desl[LARGURA_SAIDA-1:0];
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Two-entry buffer: output register plus skid register
  // ---------------------------------------------------------------------------
  logic                     r_saida_valida;
  logic [LARGURA_SAIDA-1:0] r_saida;
  logic                     r_estouro;
  logic                     r_skid_valido;
  logic [LARGURA_SAIDA-1:0] r_skid;
  logic                     r_skid_estouro;

  logic w_aceita;
  logic w_conclui;
  logic w_saida_livre;

  // The skid register is only ever filled while the output register is busy,
  // so "skid empty" is the same as "fewer than two items held".
  assign entrada_pronta = ~r_skid_valido & ~reset;
  assign w_aceita       = entrada_valida & entrada_pronta;
  assign w_conclui      = r_saida_valida & saida_pronta;
  assign w_saida_livre  = ~r_saida_valida | w_conclui;

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_saida_valida <= 1'b0;
      r_saida        <= '0;
      r_estouro      <= 1'b0;
      r_skid_valido  <= 1'b0;
      r_skid         <= '0;
      r_skid_estouro <= 1'b0;
    end else if (w_saida_livre) begin
      // Older skid item always goes first to keep FIFO order.
      if (r_skid_valido) begin
        r_saida_valida <= 1'b1;
        r_saida        <= r_skid;
        r_estouro      <= r_skid_estouro;
        r_skid_valido  <= 1'b0;
      end else if (w_aceita) begin
        r_saida_valida <= 1'b1;
        r_saida        <= w_resultado;
        r_estouro      <= w_estouro;
      end else begin
        r_saida_valida <= 1'b0;
      end
    end else if (w_aceita) begin
      // Output held by backpressure: park the new item in the skid register.
      r_skid_valido  <= 1'b1;
      r_skid         <= w_resultado;
      r_skid_estouro <= w_estouro;
    end
  end

  assign saida_valida = r_saida_valida;
  assign saida        = r_saida;
  assign estouro      = r_estouro;
  assign ocupacao     = {1'b0, r_saida_valida} + {1'b0, r_skid_valido};

endmodule
